mem_misalign_ctrl: RTL and testbench

- Memory-stage controller sitting directly upstream of data_mem_top, between the pipeline MEM stage and the data memory.
- Aligned loads/stores pass straight through in one cycle.
- Misaligned halfword/word accesses are split into sequential byte accesses, with the pipeline stalled until done; loads are reassembled and sign/zero-extended.
- data_mem_top read path is combinational (async read); writes commit on the rising clk_i edge.

---
 rtl/mem_misalign_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_misalign_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_misalign_ctrl.sv
// mem_misalign_ctrl
// Memory-stage controller in front of data_mem_top. Aligned accesses are passed straight
// through in the same cycle. A misaligned halfword or word access is split into byte
// accesses issued in ascending address order, one per cycle. The pipeline is stalled until
// the access completes, and load bytes are reassembled and then sign- or zero-extended.
//
// Ports
//   clk_i            clock; all state updates on the rising edge
//   rst_n_i          synchronous active-low reset
//   req_valid_i      MEM stage has an access this cycle
//   req_we_i         1 = store, 0 = load
//   req_type_i       00 byte, 01 half, 10 word, 11 reserved (treated as aligned)
//   req_sign_i       load extension: 1 = sign, 0 = zero
//   req_addr_i       byte address
//   req_wdata_i      store data, right-justified
//   stall_o          hold the MEM stage and all earlier stages
//   resp_valid_o     access completes this cycle
//   resp_rdata_o     extended load result; 0 for stores
//   dm_write_en_o    to data_mem_top write_en_i
//   dm_mem_type_o    to data_mem_top mem_type_i
//   dm_mem_sign_o    to data_mem_top mem_sign_i
//   dm_addr_o        to data_mem_top addr_i
//   dm_write_data_o  to data_mem_top write_data_i
//   dm_read_data_i   from data_mem_top read_data_o (asynchronous read)
module mem_misalign_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [1:0]            req_type_i,
  input  logic                  req_sign_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [ADDR_WIDTH-1:0] req_wdata_i,
  output logic                  stall_o,
  output logic                  resp_valid_o,
  output logic [ADDR_WIDTH-1:0] resp_rdata_o,
  output logic                  dm_write_en_o,
  output logic [1:0]            dm_mem_type_o,
  output logic                  dm_mem_sign_o,
  output logic [ADDR_WIDTH-1:0] dm_addr_o,
  output logic [ADDR_WIDTH-1:0] dm_write_data_o,
  input  logic [ADDR_WIDTH-1:0] dm_read_data_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSplit = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [1:0] TypeByte = 2'b00;
  localparam logic [1:0] TypeHalf = 2'b01;
  localparam logic [1:0] TypeWord = 2'b10;

  logic [1:0]            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic                  we_q, we_d;
  logic [1:0]            type_q, type_d;
  logic                  sign_q, sign_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] asm_q, asm_d;

  logic                  misaligned;
  logic [1:0]            last_idx;
  logic [4:0]            byte_lsb;
  logic [ADDR_WIDTH-1:0] load_result;

  // Byte accesses are never misaligned; the reserved type always passes through.
  assign misaligned = ((req_type_i == TypeHalf) && req_addr_i[0]) ||
                      ((req_type_i == TypeWord) && (req_addr_i[1:0] != 2'b00));

  assign last_idx = (type_q == TypeHalf) ? 2'd1 : 2'd3;
  assign byte_lsb = {idx_q, 3'b000};

  // Only half and word accesses are ever split, so only those two cases need extending.
  assign load_result = (type_q == TypeHalf) ?
                       {{(ADDR_WIDTH-16){asm_q[15] & sign_q}}, asm_q[15:0]} : asm_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    type_d  = type_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;

    stall_o         = 1'b0;
    resp_valid_o    = 1'b0;
    resp_rdata_o    = '0;
    dm_write_en_o   = 1'b0;
    dm_mem_type_o   = TypeByte;
    dm_mem_sign_o   = 1'b0;
    dm_addr_o       = '0;
    dm_write_data_o = '0;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (misaligned) begin
            // Capture only; the first byte access goes out next cycle.
            stall_o = 1'b1;
            we_d    = req_we_i;
            type_d  = req_type_i;
            sign_d  = req_sign_i;
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
            asm_d   = '0;
            idx_d   = 2'd0;
            state_d = StSplit;
          end else begin
            dm_write_en_o   = req_we_i;
            dm_mem_type_o   = req_type_i;
            dm_mem_sign_o   = req_sign_i;
            dm_addr_o       = req_addr_i;
            dm_write_data_o = req_wdata_i;
            resp_valid_o    = 1'b1;
            resp_rdata_o    = req_we_i ? '0 : dm_read_data_i;
          end
        end
      end

      StSplit: begin
        stall_o         = 1'b1;
        dm_write_en_o   = we_q;
        dm_addr_o       = addr_q + ADDR_WIDTH'(idx_q);
        dm_write_data_o = ADDR_WIDTH'(wdata_q[byte_lsb +: 8]);
        if (!we_q) begin
          asm_d[byte_lsb +: 8] = dm_read_data_i[7:0];
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == last_idx) begin
          state_d = StDone;
        end
      end

      StDone: begin
        // The MEM stage still holds the same request here; it is deliberately ignored.
        resp_valid_o = 1'b1;
        resp_rdata_o = we_q ? '0 : load_result;
        state_d      = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Reset aborts at once: no memory write or response may escape in the reset cycle.
    if (!rst_n_i) begin
      stall_o         = 1'b0;
      resp_valid_o    = 1'b0;
      resp_rdata_o    = '0;
      dm_write_en_o   = 1'b0;
      dm_mem_type_o   = TypeByte;
      dm_mem_sign_o   = 1'b0;
      dm_addr_o       = '0;
      dm_write_data_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      we_q    <= 1'b0;
      type_q  <= TypeByte;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      type_q  <= type_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
    end
  end

endmodule

// File: tb/tb_mem_misalign_ctrl.sv
// Testbench for mem_misalign_ctrl: a small byte memory stands in for data_mem_top, and a
// reference byte image predicts responses, stall lengths and the exact memory write stream.
module tb_mem_misalign_ctrl;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_we, req_sign;
  logic [1:0]    req_type;
  logic [AW-1:0] req_addr, req_wdata;
  logic          stall_o, resp_valid_o, dm_write_en_o, dm_mem_sign_o;
  logic [AW-1:0] resp_rdata_o, dm_addr_o, dm_write_data_o, dm_read_data;
  logic [1:0]    dm_mem_type_o;

  always #5 clk = ~clk;

  mem_misalign_ctrl #(.ADDR_WIDTH(AW)) u_dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_we_i       (req_we),
    .req_type_i     (req_type),
    .req_sign_i     (req_sign),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .stall_o        (stall_o),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .dm_write_en_o  (dm_write_en_o),
    .dm_mem_type_o  (dm_mem_type_o),
    .dm_mem_sign_o  (dm_mem_sign_o),
    .dm_addr_o      (dm_addr_o),
    .dm_write_data_o(dm_write_data_o),
    .dm_read_data_i (dm_read_data)
  );

  // data_mem_top stand-in: 4 KiB, address taken modulo 4096, async read.
  bit [7:0]    mem     [4096];
  bit [7:0]    ref_mem [4096];
  logic [31:0] mem_raw;

  always_comb begin
    mem_raw = {mem[12'(dm_addr_o + 32'd3)], mem[12'(dm_addr_o + 32'd2)],
               mem[12'(dm_addr_o + 32'd1)], mem[12'(dm_addr_o)]};
    case (dm_mem_type_o)
      2'b00:   dm_read_data = {{24{mem_raw[7] & dm_mem_sign_o}}, mem_raw[7:0]};
      2'b01:   dm_read_data = {{16{mem_raw[15] & dm_mem_sign_o}}, mem_raw[15:0]};
      default: dm_read_data = mem_raw;
    endcase
  end

  always @(posedge clk) begin
    if (dm_write_en_o) begin
      mem[12'(dm_addr_o)] <= dm_write_data_o[7:0];
      if (dm_mem_type_o != 2'b00) mem[12'(dm_addr_o + 32'd1)] <= dm_write_data_o[15:8];
      if (dm_mem_type_o[1]) begin
        mem[12'(dm_addr_o + 32'd2)] <= dm_write_data_o[23:16];
        mem[12'(dm_addr_o + 32'd3)] <= dm_write_data_o[31:24];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_rdata_q[$];
  int          exp_stall_q[$];
  logic [65:0] exp_wr_q[$];  // {type, addr, data}

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: byte-granular memory image, access rules applied directly.
  function automatic void model(logic we, logic [1:0] ty, logic sg, logic [31:0] a,
                                logic [31:0] wd);
    logic        mis;
    int          n;
    logic [31:0] v;
    mis = (ty == 2'b01 && a[0]) || (ty == 2'b10 && a[1:0] != 2'b00);
    n   = (ty == 2'b00) ? 1 : (ty == 2'b01) ? 2 : 4;
    v   = 32'h0;
    if (we) begin
      for (int i = 0; i < n; i++) begin
        ref_mem[12'(a + 32'(i))] = wd[8*i +: 8];
        if (mis) exp_wr_q.push_back({2'b00, a + 32'(i), 24'h0, wd[8*i +: 8]});
      end
      if (!mis) exp_wr_q.push_back({ty, a, wd});
    end else begin
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[12'(a + 32'(i))];
      if (sg && ty == 2'b00) v = {{24{v[7]}}, v[7:0]};
      if (sg && ty == 2'b01) v = {{16{v[15]}}, v[15:0]};
    end
    exp_rdata_q.push_back(v);
    exp_stall_q.push_back(!mis ? 0 : (ty == 2'b01) ? 3 : 5);
  endfunction

  // Monitor: responses, stall run length and memory writes against the scoreboard.
  int stall_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) stall_cnt = 0;
      else if (stall_o) stall_cnt++;
      if (resp_valid_o) begin
        if (exp_rdata_q.size() == 0) begin
          check("unexpected_resp", 128'(resp_rdata_o), 128'hdead);
        end else begin
          check("resp_rdata", 128'(resp_rdata_o), 128'(exp_rdata_q.pop_front()));
          check("stall_cycles", 128'(stall_cnt), 128'(exp_stall_q.pop_front()));
        end
        stall_cnt = 0;
      end
      if (dm_write_en_o) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", 128'({dm_mem_type_o, dm_addr_o, dm_write_data_o}),
                128'hdead);
        end else begin
          check("mem_write", 128'({dm_mem_type_o, dm_addr_o, dm_write_data_o}),
                128'(exp_wr_q.pop_front()));
        end
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return 128'({stall_o, resp_valid_o, resp_rdata_o, dm_write_en_o, dm_mem_type_o,
                 dm_mem_sign_o, dm_addr_o, dm_write_data_o});
  endfunction

  task automatic issue(input logic we, input logic [1:0] ty, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    model(we, ty, sg, a, wd);
    req_valid = 1'b1;
    req_we    = we;
    req_type  = ty;
    req_sign  = sg;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall_o) break;
      n++;
      if (n > 20) begin
        check("stall_timeout", 128'(n), 128'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    check(name, all_outs(), 128'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbad;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_type = 2'b00; req_sign = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 128'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_check("idle_after_reset");

    // Aligned word store then load.
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    // Misaligned word store then load.
    issue(1'b1, 2'b10, 1'b0, 32'h103, 32'h11223344);
    issue(1'b0, 2'b10, 1'b0, 32'h103, 32'h0);
    // Misaligned half loads, signed and unsigned.
    issue(1'b1, 2'b00, 1'b0, 32'h201, 32'h80);
    issue(1'b1, 2'b00, 1'b0, 32'h202, 32'hFF);
    issue(1'b0, 2'b01, 1'b1, 32'h201, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h201, 32'h0);
    // Address wrap on a misaligned half load.
    issue(1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'hA5);
    issue(1'b1, 2'b00, 1'b0, 32'h0, 32'h5A);
    issue(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0);
    idle_check("idle_between");

    // Reset during the third split cycle of a misaligned word store at 0x301.
    for (int i = 0; i < 4; i++) issue(1'b1, 2'b00, 1'b0, 32'h301 + 32'(i), 32'hC1 + 32'(i));
    ref_mem[12'h301] = 8'hDD;
    ref_mem[12'h302] = 8'hCC;
    exp_wr_q.push_back({2'b00, 32'h301, 32'hDD});
    exp_wr_q.push_back({2'b00, 32'h302, 32'hCC});
    req_valid = 1'b1; req_we = 1'b1; req_type = 2'b10; req_sign = 1'b0;
    req_addr = 32'h301; req_wdata = 32'hAABBCCDD;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_reset_cycle", all_outs(), 128'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_check("abort_after_reset");
    issue(1'b0, 2'b10, 1'b0, 32'h301, 32'h0);

    // Byte load and reserved type pass straight through.
    issue(1'b1, 2'b00, 1'b0, 32'h3, 32'h9C);
    issue(1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 32'h2, 32'h76543210);
    issue(1'b0, 2'b11, 1'b0, 32'h2, 32'h0);

    // Randomised traffic in a small window so loads see earlier stores.
    for (int k = 0; k < 200; k++) begin
      logic [1:0] ty;
      ty = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), ty, 1'($urandom_range(0, 1)),
            32'h400 + 32'($urandom_range(0, 63)), $urandom());
      if ($urandom_range(0, 3) == 0) idle_check("idle_random");
    end

    repeat (3) @(posedge clk);
    check("resp_drain", 128'(exp_rdata_q.size()), 128'd0);
    check("write_drain", 128'(exp_wr_q.size()), 128'd0);
    nbad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] != ref_mem[i]) nbad++;
    check("mem_image", 128'(nbad), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
